// File: rtl/xif_result_arbiter.sv
// xif_result_arbiter: round-robin merge of N_COPROC X-interface result channels
//   into one registered result channel toward the core.
// Latency: 1 cycle from a source handshake to result_valid_o.
// Backpressure: a full output with result_ready_i=0 holds every result_ready_o low;
//   result_ready_i reaches result_ready_o combinationally, so drain and load can
//   share a cycle.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   result_valid_i [N]   per-source result valid
//   result_ready_o [N]   per-source result ready (at most one bit set)
//   result_i [N*W]       per-source payloads, source i at bits [i*W +: W]
//   result_valid_o       output register full
//   result_ready_i       core accepts result_o this cycle
//   result_o [W]         registered payload
//   result_src_o         index of the source that produced result_o
//
// RESULT_W is normally overridden with $bits(x_result_t) of the core config.
// N_COPROC is normally overridden with the tile package's coprocessor count.
module xif_result_arbiter #(
  parameter int N_COPROC = 4,
  parameter int RESULT_W = 64,
  parameter int SRC_W    = (N_COPROC > 1) ? $clog2(N_COPROC) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N_COPROC-1:0]          result_valid_i,
  output logic [N_COPROC-1:0]          result_ready_o,
  input  logic [N_COPROC*RESULT_W-1:0] result_i,
  output logic                         result_valid_o,
  input  logic                         result_ready_i,
  output logic [RESULT_W-1:0]          result_o,
  output logic [SRC_W-1:0]             result_src_o
);

  logic                r_full;
  logic [RESULT_W-1:0] r_result;
  logic [SRC_W-1:0]    r_src;
  logic [SRC_W-1:0]    r_ptr;

  logic                w_load_en;
  logic                w_any;
  logic                w_load;
  logic [SRC_W-1:0]    w_win;
  logic [N_COPROC-1:0] w_grant;
  logic [RESULT_W-1:0] w_sel;
  logic [SRC_W-1:0]    w_ptr_nxt;
  int                  w_dist;
  int                  w_best;

  // The buffer can take a new result when it is empty or is being drained now.
  assign w_load_en = !r_full || result_ready_i;
  assign w_any     = |result_valid_i;
  assign w_load    = w_load_en && w_any;

  // Winner = valid source with the smallest wrap-around distance from r_ptr.
  // With N_COPROC=1 r_ptr never leaves 0, so this reduces to grant = valid.
  always_comb begin
    w_best = N_COPROC;
    w_dist = 0;
    w_win  = '0;
    for (int i = 0; i < N_COPROC; i++) begin
      w_dist = i - int'(r_ptr);
      if (w_dist < 0) begin
        w_dist = w_dist + N_COPROC;
      end
      if (result_valid_i[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_win  = SRC_W'(i);
      end
    end
  end

  always_comb begin
    w_grant = '0;
    w_sel   = '0;
    for (int i = 0; i < N_COPROC; i++) begin
      if (w_any && (w_win == SRC_W'(i))) begin
        w_grant[i] = 1'b1;
        w_sel      = result_i[i*RESULT_W +: RESULT_W];
      end
    end
  end

  always_comb begin
    if (int'(w_win) == N_COPROC - 1) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_win + SRC_W'(1);
    end
  end

  assign result_ready_o = w_grant & {N_COPROC{w_load_en}};

  // Payload and source hold their last value after a drain with no reload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_full   <= 1'b0;
      r_result <= '0;
      r_src    <= '0;
      r_ptr    <= '0;
    end else if (w_load) begin
      r_full   <= 1'b1;
      r_result <= w_sel;
      r_src    <= w_win;
      r_ptr    <= w_ptr_nxt;
    end else if (result_ready_i) begin
      r_full   <= 1'b0;
    end
  end

  assign result_valid_o = r_full;
  assign result_o       = r_result;
  assign result_src_o   = r_src;

endmodule

// File: tb/tb_xif_result_arbiter.sv
module tb_xif_result_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   vld;
  logic [N-1:0]   rdy_o;
  logic [N*W-1:0] dat;
  logic           vo;
  logic           ri;
  logic [W-1:0]   ro;
  logic [1:0]     so;

  logic           v1, r1o, vo1, ri1, s1;
  logic [W-1:0]   d1, o1;

  xif_result_arbiter #(.N_COPROC(N), .RESULT_W(W)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_ni),
    .result_valid_i(vld), .result_ready_o(rdy_o), .result_i(dat),
    .result_valid_o(vo), .result_ready_i(ri), .result_o(ro), .result_src_o(so)
  );

  xif_result_arbiter #(.N_COPROC(1), .RESULT_W(W)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_ni),
    .result_valid_i(v1), .result_ready_o(r1o), .result_i(d1),
    .result_valid_o(vo1), .result_ready_i(ri1), .result_o(o1), .result_src_o(s1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Source model: pend[i] results waiting, seq[i] is the sequence number on the bus.
  int pend[N];
  int seq[N];
  // Reference model of the arbiter: rotation pointer, buffer occupancy, and
  // the expected output stream as {src[7:0], payload[31:0]}.
  int          m_ptr;
  bit          m_full;
  logic [39:0] expq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] pay(input int s, input int q);
    logic [7:0]  sb;
    logic [23:0] qb;
    sb = s[7:0];
    qb = q[23:0];
    return {sb, qb};
  endfunction

  // One clock cycle of the N=4 environment with the given core ready.
  task automatic step(input bit core_rdy);
    bit            le;
    int            win;
    int            j;
    logic [N-1:0]  exp_rdy;
    logic [N-1:0]  hs;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      vld[i] = (pend[i] > 0);
      dat[i*W +: W] = pay(i, seq[i]);
    end
    ri = core_rdy;
    #1;
    le  = !m_full || core_rdy;
    win = -1;
    for (int off = 0; off < N; off++) begin
      j = (m_ptr + off) % N;
      if (win < 0 && vld[j]) win = j;
    end
    exp_rdy = '0;
    if (le && win >= 0) exp_rdy[win] = 1'b1;
    chk("ready_o", 64'(rdy_o), 64'(exp_rdy));
    chk("valid_o", 64'(vo), 64'(m_full));
    if (le && win >= 0) begin
      expq.push_back({8'(win), pay(win, seq[win])});
      m_full = 1'b1;
      m_ptr  = (win + 1) % N;
    end else if (core_rdy) begin
      m_full = 1'b0;
    end
    hs = vld & rdy_o;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        pend[i]--;
        seq[i]++;
      end
    end
  endtask

  function automatic bit busy();
    bit b;
    b = m_full;
    for (int i = 0; i < N; i++) if (pend[i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input int max_cyc);
    int c;
    c = 0;
    while (busy() && c < max_cyc) begin
      step(1'b1);
      c++;
    end
    chk("drain_done", 64'(busy()), 64'(0));
  endtask

  // Output monitor: pops the scoreboard on every output handshake and checks
  // that a stalled output does not change.
  bit          hold = 1'b0;
  logic [31:0] hold_d;
  logic [1:0]  hold_s;
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_ni && vo) begin
        if (hold) begin
          chk("hold_data", 64'(ro), 64'(hold_d));
          chk("hold_src", 64'(so), 64'(hold_s));
        end
        if (ri) begin
          chk("expected_pending", 64'(expq.size() != 0), 64'(1));
          if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("out_data", 64'(ro), 64'(e[31:0]));
            chk("out_src", 64'(so), 64'(e[33:32]));
          end
          hold = 1'b0;
        end else begin
          hold   = 1'b1;
          hold_d = ro;
          hold_s = so;
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int          sent, got, cyc;
    bit          m1_full, hs1;
    logic [31:0] exp1[$];
    logic [31:0] e1;

    vld = '0; dat = '0; ri = 1'b0;
    v1 = 1'b0; d1 = '0; ri1 = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      seq[i]  = 0;
    end
    m_ptr = 0; m_full = 1'b0;

    // Reset state: outputs cleared, ready follows grant from ptr=0.
    #1;
    vld = 4'b0110;
    #1;
    chk("rst_ready_o", 64'(rdy_o), 64'(4'b0010));
    chk("rst_valid_o", 64'(vo), 64'(0));
    chk("rst_result_o", 64'(ro), 64'(0));
    chk("rst_src_o", 64'(so), 64'(0));
    chk("rst_valid1_o", 64'(vo1), 64'(0));
    chk("rst_result1_o", 64'(o1), 64'(0));
    vld = '0;
    #20;
    @(posedge clk);
    #2 rst_ni = 1'b1;

    // Single source 2, payload low byte 0xA5; then 0 and 3 compete, ptr=3 picks 3.
    seq[2] = 'hA5;
    pend[2] = 1;
    step(1'b1);
    step(1'b1);
    pend[0] = 1; pend[3] = 1;
    drain(20);

    // Round-robin among 0, 1, 3 with no bubbles.
    pend[0] = 3; pend[1] = 3; pend[3] = 3;
    drain(40);

    // Backpressure: full with src 1, stalled 5 cycles while 0 and 2 wait.
    pend[1] = 1;
    step(1'b1);
    pend[0] = 1; pend[2] = 1;
    for (int k = 0; k < 5; k++) step(1'b0);
    step(1'b1);
    drain(20);

    // Idle cycles with ready high: output empties, ptr holds.
    step(1'b1);
    step(1'b1);
    pend[0] = 1; pend[1] = 1; pend[2] = 1; pend[3] = 1;
    drain(20);

    // Asynchronous reset while full with sources waiting.
    pend[0] = 2; pend[2] = 2;
    step(1'b1);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      vld[i] = (pend[i] > 0);
      dat[i*W +: W] = pay(i, seq[i]);
    end
    ri = 1'b0;
    #3 rst_ni = 1'b0;
    #1;
    chk("async_rst_valid_o", 64'(vo), 64'(0));
    chk("async_rst_src_o", 64'(so), 64'(0));
    chk("async_rst_ready_o", 64'(rdy_o), 64'(4'b0001));
    m_full = 1'b0; m_ptr = 0;
    expq.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst_ni = 1'b1;
    drain(20);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) pend[i]++;
      step($urandom_range(0, 9) < 7);
    end
    drain(400);
    chk("scoreboard_empty", 64'(expq.size()), 64'(0));

    // N_COPROC=1: 10-result burst with random core ready.
    m1_full = 1'b0; sent = 0; got = 0; cyc = 0;
    while (got < 10 && cyc < 300) begin
      @(negedge clk);
      v1  = (sent < 10);
      d1  = 32'hC000_0000 + 32'(sent);
      ri1 = 1'($urandom_range(0, 1));
      #1;
      chk("n1_ready_o", 64'(r1o), 64'(v1 && (!m1_full || ri1)));
      chk("n1_valid_o", 64'(vo1), 64'(m1_full));
      if (vo1 && ri1) begin
        chk("n1_expected_pending", 64'(exp1.size() != 0), 64'(1));
        if (exp1.size() != 0) begin
          e1 = exp1.pop_front();
          chk("n1_data", 64'(o1), 64'(e1));
        end
        chk("n1_src", 64'(s1), 64'(0));
        got++;
      end
      if ((!m1_full || ri1) && v1) begin
        exp1.push_back(d1);
        m1_full = 1'b1;
      end else if (ri1) begin
        m1_full = 1'b0;
      end
      hs1 = v1 && r1o;
      @(posedge clk);
      if (hs1) sent++;
      cyc++;
    end
    chk("n1_count", 64'(got), 64'(10));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
